// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared constants and small helper functions for the BCD counter slice.
// The digit bounds and direction encodings are defined here so that every
// decade, and anything else that works on BCD, uses the same values.
//
// Contents:
//   BCD_MAX / BCD_MIN  largest and smallest legal decimal digit
//   DIR_UP / DIR_DOWN  encodings of the up_down input
//   bcd_valid          true when a nibble is a legal decimal digit
//   bcd_inc / bcd_dec  one-digit modulo-10 increment / decrement
//   bcd_at_limit       true when a digit passes carry/borrow in a direction
// ---------------------------------------------------------------------------
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_MIN  = 4'd0;
  localparam logic       DIR_UP   = 1'b1;
  localparam logic       DIR_DOWN = 1'b0;

  // A nibble is a legal decimal digit when it lies in 0..9.
  function automatic logic bcd_valid(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

  // Any value at or above 9 wraps to 0, so even an undefined power-up
  // value is steered back into the legal range on its first increment.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? BCD_MIN : (d + 4'd1);
  endfunction

  // An out-of-range value is pulled down to 9 rather than to 14, 13, ...
  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    if (d == BCD_MIN) begin
      return BCD_MAX;
    end
    if (d > BCD_MAX) begin
      return BCD_MAX;
    end
    return d - 4'd1;
  endfunction

  // A digit forwards the step to the next decade when it is about to roll
  // over: 9 while counting up, 0 while counting down.
  function automatic logic bcd_at_limit(input logic [3:0] d, input logic dir);
    return (dir == DIR_UP) ? (d == BCD_MAX) : (d == BCD_MIN);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One decimal decade of the up/down counter. The decade holds a registered
// digit, steps when step_in is high, and passes carry or borrow to the next
// decade through step_out in the same cycle.
//
// Ports:
//   clock      in   rising-edge clock
//   clear      in   synchronous active-high reset, digit -> 0
//   load       in   parallel preset strobe, overrides stepping
//   load_digit in 4 preset nibble; values above 9 are stored as 0
//   step_in    in   step request from the lower decade (enable for digit 0)
//   up_down    in   1 = increment, 0 = decrement
//   digit      out 4 registered decimal digit
//   step_out   out  combinational carry/borrow into the next decade
//   bad_load   out  combinational flag: this nibble was loaded while > 9
// ---------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step_in,
  input  logic       up_down,
  output logic [3:0] digit,
  output logic       step_out,
  output logic       bad_load
);

  logic [3:0] digit_next;
  logic       load_ok;

  assign load_ok = bcd_valid(load_digit);

  // Next-digit selection. Load wins over stepping, and an illegal preset
  // nibble is replaced by 0 so the count never leaves BCD.
  always_comb begin
    digit_next = digit;
    if (load) begin
      digit_next = load_ok ? load_digit : BCD_MIN;
    end else if (step_in) begin
      digit_next = (up_down == DIR_UP) ? bcd_inc(digit) : bcd_dec(digit);
    end
  end

  // Digit register with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      digit <= BCD_MIN;
    end else begin
      digit <= digit_next;
    end
  end

  // Carry/borrow ripples combinationally so a whole multi-decade step lands
  // on one edge. A load cycle never steps, so it never carries either.
  assign step_out = step_in & ~load & bcd_at_limit(digit, up_down);

  assign bad_load = load & ~load_ok;

endmodule

// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
// Multi-decade synchronous BCD up/down counter with parallel preset, preset
// validity checking and a wrap pulse on roll-over / roll-under.
//
// Parameters:
//   DIGITS      number of decimal decades (1..8); count is 4*DIGITS bits
//
// Ports:
//   clock       in          rising-edge clock
//   clear       in          synchronous active-high reset
//   enable      in          step strobe, one step per edge while high
//   up_down     in          1 = increment, 0 = decrement
//   load        in          parallel preset strobe (beats enable)
//   load_value  in  4*DIGITS preset, digit k in bits [4k+3:4k]
//   count       out 4*DIGITS registered BCD count, digit 0 least significant
//   wrap        out         one-cycle pulse after a roll-over or roll-under
//   load_error  out         one-cycle pulse after a load with a digit > 9
// ---------------------------------------------------------------------------
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  load_error
);

  // step_chain[k] is the step request into decade k; the extra top bit is
  // the carry/borrow out of the most significant decade.
  logic [DIGITS:0]   step_chain;
  logic [DIGITS-1:0] bad_load_vec;

  assign step_chain[0] = enable;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_decade
    bcd_digit u_digit (
      .clock      (clock),
      .clear      (clear),
      .load       (load),
      .load_digit (load_value[4*gi +: 4]),
      .step_in    (step_chain[gi]),
      .up_down    (up_down),
      .digit      (count[4*gi +: 4]),
      .step_out   (step_chain[gi+1]),
      .bad_load   (bad_load_vec[gi])
    );
  end

  // Status pulses. The top carry is already suppressed on load cycles, so
  // wrap only needs clear to override it; load_error is a plain OR of the
  // per-decade flags, which are themselves qualified by load.
  always_ff @(posedge clock) begin
    if (clear) begin
      wrap       <= 1'b0;
      load_error <= 1'b0;
    end else begin
      wrap       <= step_chain[DIGITS];
      load_error <= |bad_load_vec;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
// Self-checking bench for the 4-decade BCD up/down counter. The reference
// model keeps the count as a plain integer 0..9999 and converts it to BCD
// with division, so it shares nothing with the decade-by-decade RTL.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

  localparam int DIGITS  = 4;
  localparam int W       = 4 * DIGITS;
  localparam int MODULUS = 10000;

  logic         clock = 1'b0;
  logic         clear;
  logic         enable;
  logic         up_down;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         wrap;
  logic         load_error;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state.
  int   model_val = 0;
  logic exp_wrap  = 1'b0;
  logic exp_err   = 1'b0;

  bcd_updown_counter #(.DIGITS(DIGITS)) dut (
    .clock      (clock),
    .clear      (clear),
    .enable     (enable),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .wrap       (wrap),
    .load_error (load_error)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Integer -> packed BCD by repeated division.
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int rem;
    r   = '0;
    rem = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit
  // later, and advance the reference model by the same edge.
  task automatic applyStimulus(input logic c, input logic l,
                               input logic [W-1:0] lv,
                               input logic en, input logic ud);
    int   v;
    int   nib;
    logic err;
    clear      = c;
    load       = l;
    load_value = lv;
    enable     = en;
    up_down    = ud;
    @(posedge clock);
    #1;
    exp_wrap = 1'b0;
    exp_err  = 1'b0;
    if (c) begin
      model_val = 0;
    end else if (l) begin
      v   = 0;
      err = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
        nib = int'(lv[4*k +: 4]);
        if (nib > 9) begin
          nib = 0;
          err = 1'b1;
        end
        v = v * 10 + nib;
      end
      model_val = v;
      exp_err   = err;
    end else if (en) begin
      if (ud) begin
        if (model_val == MODULUS - 1) begin
          model_val = 0;
          exp_wrap  = 1'b1;
        end else begin
          model_val = model_val + 1;
        end
      end else begin
        if (model_val == 0) begin
          model_val = MODULUS - 1;
          exp_wrap  = 1'b1;
        end else begin
          model_val = model_val - 1;
        end
      end
    end
  endtask

  // Clear brings every output to zero.
  task automatic test_reset();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (count !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_count: got %h, expected %h", count, 16'h0000);
    end
    vectors++;
    if (wrap !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_wrap: got %b, expected %b", wrap, 1'b0);
    end
    vectors++;
    if (load_error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_load_error: got %b, expected %b", load_error, 1'b0);
    end
  endtask

  // Count up through the full 0000..9999 range and back to 0000.
  task automatic test_count_up_full();
    logic [W-1:0] exp_count;
    for (int i = 1; i <= MODULUS; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
      exp_count = to_bcd(i % MODULUS);
      vectors++;
      if (count !== exp_count) begin
        miscompares++;
        $display("[TB] FAIL up_full_count step %0d: got %h, expected %h", i, count, exp_count);
      end
      vectors++;
      if (wrap !== (i == MODULUS)) begin
        miscompares++;
        $display("[TB] FAIL up_full_wrap step %0d: got %b, expected %b", i, wrap, (i == MODULUS));
      end
    end
  endtask

  // Borrow across a decade and roll-under from zero.
  task automatic test_down_loads();
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (count !== 16'h0099 || wrap !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL down_borrow: got %h/%b, expected %h/%b", count, wrap, 16'h0099, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (count !== 16'h9999 || wrap !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL down_rollunder: got %h/%b, expected %h/%b", count, wrap, 16'h9999, 1'b1);
    end
  endtask

  // Illegal nibble is zeroed and flagged; a legal load clears the flag.
  task automatic test_load_error();
    applyStimulus(1'b0, 1'b1, 16'h12F4, 1'b0, 1'b0);
    vectors++;
    if (count !== 16'h1204 || load_error !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bad_load: got %h/%b, expected %h/%b", count, load_error, 16'h1204, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0);
    vectors++;
    if (count !== 16'h0042 || load_error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL good_load: got %h/%b, expected %h/%b", count, load_error, 16'h0042, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 16'hA000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h000B, 1'b0, 1'b0);
    vectors++;
    if (count !== 16'h0000 || load_error !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bad_load_b2b: got %h/%b, expected %h/%b", count, load_error, 16'h0000, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (load_error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_error_hold: got %b, expected %b", load_error, 1'b0);
    end
  endtask

  // Direction changes on consecutive steps around a decade boundary.
  task automatic test_direction_toggle();
    logic [W-1:0] exp_seq [4];
    logic         dir_seq [4];
    exp_seq = '{16'h0999, 16'h1000, 16'h0999, 16'h0998};
    dir_seq = '{1'b1, 1'b1, 1'b0, 1'b0};
    applyStimulus(1'b0, 1'b1, 16'h0998, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1, dir_seq[i]);
      vectors++;
      if (count !== exp_seq[i] || wrap !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL toggle step %0d: got %h/%b, expected %h/%b", i, count, wrap, exp_seq[i], 1'b0);
      end
    end
  endtask

  // Clear beats a pending wrap; load beats enable.
  task automatic test_priority();
    applyStimulus(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (count !== 16'h0000 || wrap !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clear_over_wrap: got %h/%b, expected %h/%b", count, wrap, 16'h0000, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 16'h0042, 1'b1, 1'b1);
    vectors++;
    if (count !== 16'h0042 || wrap !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_over_enable: got %h/%b, expected %h/%b", count, wrap, 16'h0042, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 16'h9999, 1'b1, 1'b1);
    vectors++;
    if (count !== 16'h9999 || wrap !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_at_max_no_wrap: got %h/%b, expected %h/%b", count, wrap, 16'h9999, 1'b0);
    end
  endtask

  // Alternating up/down across the 9999/0000 seam wraps on every edge.
  task automatic test_back_to_back();
    logic [W-1:0] exp_count;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1, (i % 2 == 0));
      exp_count = (i % 2 == 0) ? 16'h0000 : 16'h9999;
      vectors++;
      if (count !== exp_count || wrap !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_wrap step %0d: got %h/%b, expected %h/%b", i, count, wrap, exp_count, 1'b1);
      end
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (count !== 16'h9999 || wrap !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_after_wrap: got %h/%b, expected %h/%b", count, wrap, 16'h9999, 1'b0);
    end
  endtask

  // Random mix of clear, load (legal and illegal), steps and holds.
  task automatic test_random();
    logic         c, l, en, ud;
    logic [W-1:0] lv;
    logic [W-1:0] exp_count;
    for (int i = 0; i < 2000; i++) begin
      c  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 10);
      en = ($urandom_range(0, 99) < 80);
      ud = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 1) begin
        lv = to_bcd(int'($urandom_range(0, MODULUS - 1)));
      end else begin
        lv = W'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        lv = ($urandom_range(0, 1) == 1) ? 16'h9999 : 16'h0000;
      end
      applyStimulus(c, l, lv, en, ud);
      exp_count = to_bcd(model_val);
      vectors++;
      if (count !== exp_count) begin
        miscompares++;
        $display("[TB] FAIL rand_count cycle %0d: got %h, expected %h", i, count, exp_count);
      end
      vectors++;
      if (wrap !== exp_wrap) begin
        miscompares++;
        $display("[TB] FAIL rand_wrap cycle %0d: got %b, expected %b", i, wrap, exp_wrap);
      end
      vectors++;
      if (load_error !== exp_err) begin
        miscompares++;
        $display("[TB] FAIL rand_load_error cycle %0d: got %b, expected %b", i, load_error, exp_err);
      end
    end
  endtask

  // Test sequence.
  initial begin
    clear      = 1'b0;
    load       = 1'b0;
    enable     = 1'b0;
    up_down    = 1'b0;
    load_value = '0;
    test_reset();
    test_count_up_full();
    test_down_loads();
    test_load_error();
    test_direction_toggle();
    test_priority();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
